inst_loader: RTL and testbench
==============================

# inst_loader

Boot-time writer for the instruction memory. Accepts a framed byte stream (from the UART receiver or a debug port), assembles big-endian 32-bit MIPS instruction words and issues sequential single-cycle writes on the instruction memory's write port. While a load is in progress the CPU core is held in reset; it is released when the image is complete and valid.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first written word; word-aligned.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1_000_000, maximum idle cycles between bytes inside a frame.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  reset; asynchronous, active-low.
- byte_i  in  8  stream byte.
- byte_valid_i  in  1  byte_i valid this cycle.
- byte_ready_o  out  1  loader accepts a byte; a byte transfers when valid and ready are both 1.
- wr_en_o  out  1  instruction-memory write strobe, one cycle per word.
- wr_addr_o  out  32  word-aligned byte address of the write.
- wr_data_o  out  32  instruction word.
- cpu_rst_n_o  out  1  active-low CPU reset; 0 holds the core.
- done_o  out  1  image loaded; CPU running.
- err_o  out  1  last frame failed.

## Operation
- Frame: SYNC_BYTE, count byte N (0 encodes 256), N×4 data bytes, then one checksum byte if LOADER_CHKSUM_EN is defined.
- Word assembly: first byte of a group → [31:24], fourth → [7:0].
- Word k is written to BASE_ADDR + 4·k, k = 0..N−1; an 8-bit word index covers the full 1 KiB region.
- States:
  - IDLE: non-sync bytes are discarded; SYNC_BYTE → COUNT.
  - COUNT: latch N → DATA.
  - DATA: 4th byte of a word → write. After word N−1 → CHECK if the macro is defined, else DONE.
  - CHECK: byte equal to running checksum → DONE, otherwise → ERR.
  - DONE: done_o=1, cpu_rst_n_o=1.
  - ERR: err_o=1, cpu_rst_n_o=0.
- From DONE or ERR, SYNC_BYTE starts a new load: → COUNT, done_o and err_o cleared, cpu_rst_n_o driven 0, word index and checksum reset.
- Timeout: an idle counter clears on every accepted byte. In COUNT, DATA and CHECK, TIMEOUT_CYCLES consecutive cycles with no transfer → ERR. The partial word is discarded. No timeout in IDLE, DONE or ERR.
- byte_ready_o is 1 in all states after reset; writes never stall the stream.

## Timing
- Reset values: byte_ready_o=0, wr_en_o=0, wr_addr_o=BASE_ADDR, wr_data_o=0, cpu_rst_n_o=0, done_o=0, err_o=0, state IDLE. byte_ready_o rises on the first clk_i edge after rst_n_i deasserts.
- wr_en_o, wr_addr_o and wr_data_o are registered and asserted for exactly the one cycle following the edge that accepted the 4th byte. wr_addr_o and wr_data_o hold their value between writes.
- done_o and cpu_rst_n_o rise together, one cycle after the final write (macro off) or one cycle after the accepted checksum byte (macro on).
- Timeout: err_o rises on the edge ending the TIMEOUT_CYCLES-th idle cycle.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronous). Writes already issued are not undone.

## Configuration
- LOADER_CHKSUM_EN defined:
  - Frame carries a trailing checksum byte: the XOR of the count byte and all data bytes.
  - A mismatch → ERR. Words already written remain in memory, and the CPU stays in reset.
- LOADER_CHKSUM_EN undefined:
  - No checksum byte and no CHECK state.
  - Frame completes after the last data byte.

## Test plan
- Macro on, stream A5 02 20 04 00 05 00 00 10 26 15:
  - wr 0x0000_0000 ← 0x2004_0005.
  - wr 0x0000_0004 ← 0x0000_1026.
  - Then done_o=1, cpu_rst_n_o=1, err_o=0.
- Leading garbage 00 FF 3C, then the same frame: garbage produces no writes; result identical to the first scenario.
- Same frame with checksum 0x16:
  - Both writes occur; err_o=1, cpu_rst_n_o=0, done_o=0.
  - Resending the correct frame clears err_o and sets done_o.
- TIMEOUT_CYCLES=16, stream A5 01 20 04 then silence: err_o=1 after 16 idle cycles, no wr_en_o pulse.
- Count byte 00 with 1024 data bytes: exactly 256 writes; the last is at BASE_ADDR+0x3FC, then done_o.
- Assert rst_n_i after A5 02 20 04 00:
  - All outputs return to reset values at once.
  - A subsequent full frame loads correctly from word 0.

Source files
------------

// File: rtl/inst_loader_if.sv
// ============================================================================
// inst_loader_if : byte-stream input and instruction-memory write port
// Revision       : 1.0
// ============================================================================
`default_nettype none

interface inst_loader_if;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_ready_o;
    logic        wr_en_o;
    logic [31:0] wr_addr_o;
    logic [31:0] wr_data_o;

    // master: stream source / memory observer; slave: the loader itself
    modport master (
        output byte_i, byte_valid_i,
        input  byte_ready_o, wr_en_o, wr_addr_o, wr_data_o
    );
    modport slave (
        input  byte_i, byte_valid_i,
        output byte_ready_o, wr_en_o, wr_addr_o, wr_data_o
    );
endinterface

`default_nettype wire

// File: rtl/inst_loader.sv
// ============================================================================
// inst_loader : framed byte stream -> big-endian 32-bit instruction writes,
//               holds the CPU in reset until the image is complete.
// Option      : LOADER_CHKSUM_EN adds a trailing XOR checksum byte + CHECK state
// Revision    : 1.0
// ============================================================================
`default_nettype none

module inst_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  wire logic     clk_i,
    input  wire logic     rst_n_i,
    inst_loader_if.slave  bus,
    output logic          cpu_rst_n_o,
    output logic          done_o,
    output logic          err_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_DATA,
`ifdef LOADER_CHKSUM_EN
        S_CHECK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    count_q, count_d;
    logic [7:0]    word_idx_q, word_idx_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [23:0]   shift_q, shift_d;
    logic [TW-1:0] idle_q, idle_d;
    logic          byte_ready_q, byte_ready_d;
    logic          wr_en_q, wr_en_d;
    logic [31:0]   wr_addr_q, wr_addr_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic          cpu_rst_n_q, cpu_rst_n_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
`ifdef LOADER_CHKSUM_EN
    logic [7:0]    chk_q, chk_d;
`endif

    logic w_xfer;
    logic w_sync;
    logic w_timed;
    logic w_timeout;

    always_comb begin
        w_xfer  = bus.byte_valid_i && byte_ready_q;
        w_sync  = w_xfer && (bus.byte_i == SYNC_BYTE);
        w_timed = (state_q == S_COUNT) || (state_q == S_DATA)
`ifdef LOADER_CHKSUM_EN
                  || (state_q == S_CHECK)
`endif
                  ;
        w_timeout = w_timed && !w_xfer && (idle_q == TW'(TIMEOUT_CYCLES - 1));

        state_d      = state_q;
        count_d      = count_q;
        word_idx_d   = word_idx_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        byte_ready_d = 1'b1;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
`ifdef LOADER_CHKSUM_EN
        chk_d        = chk_q;
`endif
        idle_d = (!w_timed || w_xfer) ? '0 : idle_q + TW'(1);

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (w_sync) begin
                    state_d    = S_COUNT;
                    word_idx_d = '0;
                    byte_cnt_d = '0;
`ifdef LOADER_CHKSUM_EN
                    chk_d      = '0;
`endif
                end
            end
            S_COUNT: begin
                if (w_xfer) begin
                    count_d = bus.byte_i;
`ifdef LOADER_CHKSUM_EN
                    chk_d   = bus.byte_i;
`endif
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (w_xfer) begin
`ifdef LOADER_CHKSUM_EN
                    chk_d = chk_q ^ bus.byte_i;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        wr_en_d    = 1'b1;
                        wr_data_d  = {shift_q, bus.byte_i};
                        wr_addr_d  = BASE_ADDR + {22'd0, word_idx_q, 2'b00};
                        word_idx_d = word_idx_q + 8'd1;
                        byte_cnt_d = 2'd0;
                        // count 0 means 256 words, so the last index wraps to 8'hFF
                        if (word_idx_q == 8'(count_q - 8'd1)) begin
`ifdef LOADER_CHKSUM_EN
                            state_d = S_CHECK;
`else
                            state_d = S_DONE;
`endif
                        end
                    end else begin
                        shift_d    = {shift_q[15:0], bus.byte_i};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
`ifdef LOADER_CHKSUM_EN
            S_CHECK: begin
                if (w_xfer) begin
                    state_d = (bus.byte_i == chk_q) ? S_DONE : S_ERR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (w_timeout) begin
            state_d = S_ERR;
        end

        err_d = (state_d == S_ERR);
`ifdef LOADER_CHKSUM_EN
        done_d = (state_d == S_DONE);
`else
        // without a checksum byte, completion shows one cycle after the final write pulse
        done_d = (state_q == S_DONE) && (state_d == S_DONE);
`endif
        cpu_rst_n_d = done_d;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            word_idx_q   <= '0;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            idle_q       <= '0;
            byte_ready_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= BASE_ADDR;
            wr_data_q    <= '0;
            cpu_rst_n_q  <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef LOADER_CHKSUM_EN
            chk_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            word_idx_q   <= word_idx_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            idle_q       <= idle_d;
            byte_ready_q <= byte_ready_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            cpu_rst_n_q  <= cpu_rst_n_d;
            done_q       <= done_d;
            err_q        <= err_d;
`ifdef LOADER_CHKSUM_EN
            chk_q        <= chk_d;
`endif
        end
    end

    assign bus.byte_ready_o = byte_ready_q;
    assign bus.wr_en_o      = wr_en_q;
    assign bus.wr_addr_o    = wr_addr_q;
    assign bus.wr_data_o    = wr_data_q;
    assign cpu_rst_n_o      = cpu_rst_n_q;
    assign done_o           = done_q;
    assign err_o            = err_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_loader.sv
// ============================================================================
// tb_inst_loader : frame table + random payloads checked against a frame-level
//                  reference model, plus timing/timeout/reset sequences.
// Revision       : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_inst_loader;

    localparam logic [31:0] TB_BASE    = 32'h0000_2000;
    localparam logic [7:0]  TB_SYNC    = 8'hA5;
    localparam int          TB_TIMEOUT = 16;
`ifdef LOADER_CHKSUM_EN
    localparam bit CHK_ON = 1'b1;
`else
    localparam bit CHK_ON = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic cpu_rst_n;
    logic done;
    logic err;

    inst_loader_if bus();

    inst_loader #(
        .BASE_ADDR      (TB_BASE),
        .SYNC_BYTE      (TB_SYNC),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .bus         (bus),
        .cpu_rst_n_o (cpu_rst_n),
        .done_o      (done),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t act_q[$];

    // write-port monitor, sampled 1 ns after each rising edge
    always @(posedge clk) begin
        wr_t w;
        #1;
        if (bus.wr_en_o === 1'b1) begin
            w.addr = bus.wr_addr_o;
            w.data = bus.wr_data_o;
            act_q.push_back(w);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.byte_i       = b;
        bus.byte_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.byte_valid_i = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " byte_ready"}, 32'(bus.byte_ready_o), 32'd0);
        check({tag, " wr_en"},      32'(bus.wr_en_o),      32'd0);
        check({tag, " wr_addr"},    bus.wr_addr_o,         TB_BASE);
        check({tag, " wr_data"},    bus.wr_data_o,         32'd0);
        check({tag, " cpu_rst_n"},  32'(cpu_rst_n),        32'd0);
        check({tag, " done"},       32'(done),             32'd0);
        check({tag, " err"},        32'(err),              32'd0);
    endtask

    task automatic release_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check({tag, " ready before edge"}, 32'(bus.byte_ready_o), 32'd0);
        @(posedge clk);
        #1;
        check({tag, " ready after edge"}, 32'(bus.byte_ready_o), 32'd1);
    endtask

    task automatic compare_writes(input string tag);
        check({tag, " write count"}, 32'(act_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < act_q.size()) begin
                check($sformatf("%s wr%0d addr", tag, i), act_q[i].addr, exp_q[i].addr);
                check($sformatf("%s wr%0d data", tag, i), act_q[i].data, exp_q[i].data);
            end
        end
        act_q.delete();
        exp_q.delete();
    endtask

    // Reference model: builds the byte stream and the expected memory writes
    // straight from the frame format, then drives the stream.
    task automatic run_frame(input int n, input int garbage, input bit bad, input int max_gap,
                             input bit exp_done, input bit exp_err, input string tag);
        logic [7:0] stream[$];
        logic [7:0] payload[$];
        logic [7:0] ck;
        logic [7:0] g;
        logic [7:0] cnt_byte;
        int         nw;
        wr_t        w;
        nw       = (n == 0) ? 256 : n;
        cnt_byte = 8'(n);
        for (int i = 0; i < garbage; i++) begin
            do g = 8'($urandom); while (g == TB_SYNC);
            stream.push_back(g);
        end
        stream.push_back(TB_SYNC);
        stream.push_back(cnt_byte);
        ck = cnt_byte;
        for (int i = 0; i < nw * 4; i++) begin
            g = 8'($urandom);
            payload.push_back(g);
            stream.push_back(g);
            ck = ck ^ g;
        end
        for (int k = 0; k < nw; k++) begin
            w.addr = TB_BASE + 32'(4 * k);
            w.data = {payload[4*k], payload[4*k+1], payload[4*k+2], payload[4*k+3]};
            exp_q.push_back(w);
        end
        if (CHK_ON) stream.push_back(bad ? (ck ^ 8'h5A) : ck);
        foreach (stream[i]) begin
            send(stream[i]);
            if (max_gap > 0) tick($urandom_range(max_gap, 0));
        end
        tick(3);
        compare_writes(tag);
        check({tag, " done"},      32'(done),      32'(exp_done));
        check({tag, " err"},       32'(err),       32'(exp_err));
        check({tag, " cpu_rst_n"}, 32'(cpu_rst_n), 32'(exp_done));
    endtask

    typedef struct {
        int n;
        int garbage;
        bit bad;
        int max_gap;
        bit exp_done;
        bit exp_err;
    } frame_vec_t;

    frame_vec_t vecs[7];

    initial begin
        bus.byte_i       = 8'h00;
        bus.byte_valid_i = 1'b0;

        vecs[0] = '{1, 0, 1'b0, 0, 1'b1, 1'b0};
        vecs[1] = '{3, 3, 1'b0, 3, 1'b1, 1'b0};
        vecs[2] = '{2, 0, 1'b1, 1, !CHK_ON, CHK_ON};
        vecs[3] = '{5, 2, 1'b0, 2, 1'b1, 1'b0};
        vecs[4] = '{0, 0, 1'b0, 0, 1'b1, 1'b0};
        vecs[5] = '{4, 1, 1'b1, 0, !CHK_ON, CHK_ON};
        vecs[6] = '{2, 0, 1'b0, 3, 1'b1, 1'b0};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        release_reset("por");

        // Worked example frame with cycle-exact output checks
        send(8'hA5); send(8'h02);
        send(8'h20); send(8'h04); send(8'h00); send(8'h05);
        check("ex wr0 en",   32'(bus.wr_en_o), 32'd1);
        check("ex wr0 addr", bus.wr_addr_o,    TB_BASE);
        check("ex wr0 data", bus.wr_data_o,    32'h2004_0005);
        send(8'h00); send(8'h00); send(8'h10); send(8'h26);
        check("ex wr1 en",   32'(bus.wr_en_o), 32'd1);
        check("ex wr1 addr", bus.wr_addr_o,    TB_BASE + 32'd4);
        check("ex wr1 data", bus.wr_data_o,    32'h0000_1026);
        check("ex done during write", 32'(done), 32'd0);
`ifdef LOADER_CHKSUM_EN
        send(8'h15);
`else
        tick(1);
`endif
        check("ex wr_en dropped", 32'(bus.wr_en_o), 32'd0);
        check("ex addr held", bus.wr_addr_o, TB_BASE + 32'd4);
        check("ex done",      32'(done),      32'd1);
        check("ex cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        check("ex err",       32'(err),       32'd0);
        check("ex write count", 32'(act_q.size()), 32'd2);
        act_q.delete();

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i].n, vecs[i].garbage, vecs[i].bad, vecs[i].max_gap,
                      vecs[i].exp_done, vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        // Timeout: frame stalls after two data bytes
        send(8'hA5);
        check("to sync clears done", 32'(done), 32'd0);
        check("to cpu held", 32'(cpu_rst_n), 32'd0);
        send(8'h01); send(8'h20); send(8'h04);
        tick(TB_TIMEOUT - 1);
        check("to err before limit", 32'(err), 32'd0);
        tick(1);
        check("to err at limit", 32'(err), 32'd1);
        check("to cpu_rst_n",    32'(cpu_rst_n), 32'd0);
        check("to no writes",    32'(act_q.size()), 32'd0);
        act_q.delete();

        // Asynchronous reset in the middle of a frame
        send(8'hA5);
        check("rst sync clears err", 32'(err), 32'd0);
        send(8'h02); send(8'h20); send(8'h04); send(8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        release_reset("midrst");
        check("midrst no writes", 32'(act_q.size()), 32'd0);
        act_q.delete();
        run_frame(2, 0, 1'b0, 1, 1'b1, 1'b0, "post_rst");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
